asr_shift_sequencer: RTL and testbench

//   Multi-step controller for the 128-bit arithmetic-right-shift datapath.
//   - Accepts an operand and a shift amount over a valid/ready handshake.
//   - Applies one sign-preserving right shift per clock until the amount is consumed.
//   - Presents the result on an output handshake.
//   - Sits between a requester (ALU / test harness) and the shift register datapath.
//   - Replaces single-step, free-running shifting with counted, interruptible operations.

---
 rtl/asr_shift_sequencer_pkg.sv | 25 ++
 rtl/asr_step.sv | 11 +
 rtl/asr_shift_sequencer.sv | 114 +++++++++++
 tb/tb_asr_shift_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/asr_shift_sequencer_pkg.sv
// Shared constants and state encoding for the counted arithmetic-right-shift sequencer.
package asr_shift_sequencer_pkg;

    localparam int WIDTH_DEF = 128;
    localparam int CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } asr_state_e;

    // The unused code 2'd3 is treated as IDLE so an upset state recovers on the next edge.
    function automatic asr_state_e state_decode(input logic [1:0] raw);
        asr_state_e dec;
        case (raw)
            2'd0:    dec = ST_IDLE;
            2'd1:    dec = ST_SHIFT;
            2'd2:    dec = ST_DONE;
            default: dec = ST_IDLE;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/asr_step.sv
// Combinational single-bit arithmetic right shift; the MSB is replicated into the vacated bit.
module asr_step #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = {din[WIDTH-1], din[WIDTH-1:1]};

endmodule

// File: rtl/asr_shift_sequencer.sv
// Counted, abortable arithmetic-right-shift controller with valid/ready handshakes on
// both the operand side and the result side.
module asr_shift_sequencer
    import asr_shift_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] amount,
    input  logic             abort,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] dout
);

    logic [1:0]       state_r;
    asr_state_e       state_s;
    asr_state_e       state_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_next_s;
    logic [WIDTH-1:0] step_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             start_ready_r;
    logic             busy_r;
    logic             done_valid_r;

    asr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .din (shreg_r),
        .dout(step_s)
    );

    assign state_s = state_decode(state_r);

    // Next-state, shift-register and down-counter update.
    always_comb begin
        state_next_s = state_s;
        shreg_next_s = shreg_r;
        cnt_next_s   = cnt_r;
        case (state_s)
            ST_IDLE: begin
                if (start_valid) begin
                    shreg_next_s = din;
                    cnt_next_s   = amount;
                    if (amount == {CNT_W{1'b0}}) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Abort leaves the partially shifted value visible on dout.
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else begin
                    shreg_next_s = step_s;
                    cnt_next_s   = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake flags; flags are derived from the next state so they
    // come straight out of flops and line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= 2'd0;
            shreg_r       <= {WIDTH{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
            done_valid_r  <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            shreg_r       <= shreg_next_s;
            cnt_r         <= cnt_next_s;
            start_ready_r <= (state_next_s == ST_IDLE);
            busy_r        <= (state_next_s != ST_IDLE);
            done_valid_r  <= (state_next_s == ST_DONE);
        end
    end

    assign start_ready = start_ready_r;
    assign busy        = busy_r;
    assign done_valid  = done_valid_r;
    assign dout        = shreg_r;

endmodule

// File: tb/tb_asr_shift_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops them
// whenever done_valid rises and checks both the data and the completion cycle.
module tb_asr_shift_sequencer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [127:0] din = 128'd0;
    logic [6:0]   amount = 7'd0;
    logic         abort = 1'b0;
    logic         busy;
    logic         done_valid;
    logic         done_ready = 1'b1;
    logic [127:0] dout;

    asr_shift_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .din        (din),
        .amount     (amount),
        .abort      (abort),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .dout       (dout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    logic prev_dv = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (!reset && done_valid && !prev_dv) begin
            if (sb.size() == 0) begin
                check("unexpected_done_valid", {127'd0, done_valid}, 128'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_dout"}, dout, mon_e.data);
                check({mon_e.name, "_latency"}, 128'(cyc), 128'(mon_e.done_cyc));
            end
        end
        prev_dv <= done_valid;
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!start_ready && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!start_ready) check({name, "_ready_timeout"}, {127'd0, start_ready}, 128'd1);
    endtask

    task automatic issue(input string name, input logic [127:0] d, input logic [6:0] a,
                         input bit expect_out, input logic [127:0] exp);
        exp_t e;
        wait_ready(name);
        din         = d;
        amount      = a;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        if (expect_out) begin
            e.data     = exp;
            e.done_cyc = cyc + int'(a);
            e.name     = name;
            sb.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_start_ready", {127'd0, start_ready}, 128'd1);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done_valid", {127'd0, done_valid}, 128'd0);
        check("rst_dout", dout, 128'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic sign-extending shifts and the zero-amount bypass.
        issue("t1", {1'b1, 127'd0}, 7'd4, 1'b1, {5'b11111, 123'd0});
        issue("t2a", {2'b01, 126'd0}, 7'd2, 1'b1, {4'b0001, 124'd0});
        issue("t2b", {2'b01, 126'd0}, 7'd0, 1'b1, {2'b01, 126'd0});
        issue("t3a", {1'b1, 126'd0, 1'b1}, 7'd127, 1'b1, {128{1'b1}});
        issue("t3b", {1'b0, 126'd0, 1'b1}, 7'd127, 1'b1, 128'd0);
        wait_ready("t3");

        // Back-pressure in DONE with start_valid and abort both held.
        done_ready = 1'b0;
        issue("t4a", {1'b1, 127'd0}, 7'd1, 1'b1, {2'b11, 126'd0});
        @(posedge clock);
        #1;
        start_valid = 1'b1;
        din         = {4'h6, 124'd0};
        amount      = 7'd3;
        abort       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_done_valid", {127'd0, done_valid}, 128'd1);
            check("t4_hold_dout", dout, {2'b11, 126'd0});
            check("t4_hold_start_ready", {127'd0, start_ready}, 128'd0);
            @(posedge clock);
            #1;
        end
        abort      = 1'b0;
        done_ready = 1'b1;
        @(posedge clock);
        #1;
        check("t4_idle_gap_ready", {127'd0, start_ready}, 128'd1);
        check("t4_idle_gap_done", {127'd0, done_valid}, 128'd0);
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        sb.push_back('{{8'h0C, 120'd0}, cyc + 3, "t4b"});
        check("t4b_accepted_busy", {127'd0, busy}, 128'd1);
        wait_ready("t4b");

        // Abort after three of ten shifts.
        issue("t5", {8'hA5, 120'd0}, 7'd10, 1'b0, 128'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("t5_start_ready", {127'd0, start_ready}, 128'd1);
        check("t5_busy", {127'd0, busy}, 128'd0);
        check("t5_done_valid", {127'd0, done_valid}, 128'd0);
        check("t5_partial_dout", dout, {8'hF4, 4'hA, 116'd0});
        repeat (12) begin
            @(posedge clock);
            #1;
        end
        check("t5_no_late_done", {127'd0, done_valid}, 128'd0);

        // Reset in the middle of a shift sequence.
        issue("t6", {1'b1, 127'd0}, 7'd20, 1'b0, 128'd0);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t6_start_ready", {127'd0, start_ready}, 128'd1);
        check("t6_busy", {127'd0, busy}, 128'd0);
        check("t6_done_valid", {127'd0, done_valid}, 128'd0);
        check("t6_dout", dout, 128'd0);

        issue("t7", {8'h81, 120'd0}, 7'd8, 1'b1, {8'hFF, 8'h81, 112'd0});
        wait_ready("t7");
        repeat (2) @(posedge clock);
        #1;
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
